instr_decode_stage: RTL and testbench
=====================================

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the datapath width; only 32 and 64 are legal.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port flush, input, 1 bit, which discards all held entries.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning upstream offers an instruction.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the stage can accept an instruction this cycle.
REQ-007 The block SHALL have ports in_instr, input, 32 bits, and in_pc, input, XLEN bits, carrying the offered instruction and its PC.
REQ-008 The block SHALL have ports out_valid, output, 1 bit, and out_ready, input, 1 bit, forming the downstream handshake.
REQ-009 The block SHALL have decoded outputs out_pc (XLEN), out_opcode (7), out_rd (5), out_rs1 (5), out_rs2 (5), out_funct3 (3), out_funct7 (7), out_imm (XLEN), out_fmt (3) and out_illegal (1).
REQ-010 The block SHALL have ports perf_decoded and perf_illegal, outputs, 32 bits each, holding event counters.

Function
REQ-011 Field extraction: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
REQ-012 out_fmt encoding: R=0, I=1, S=2, B=3, U=4, J=5; illegal instructions report 0.
REQ-013 out_imm SHALL be the I/S/B/U/J immediate sign-extended from bit 31 to XLEN bits, or 0 for R-type and illegal.
REQ-014 out_illegal=1 for any of the following:
  - bits[1:0] != 2'b11;
  - opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM};
  - JALR with funct3 != 0;
  - BRANCH with funct3 of 010 or 011;
  - OP with funct7 not in {0x00, 0x20};
  - LOAD funct3=111;
  - STORE funct3 > 3.
REQ-015 When XLEN=64, OP-IMM-32 and OP-32 SHALL additionally be legal.
REQ-016 When XLEN=32, the following SHALL additionally be illegal: LD (funct3=011), LWU (funct3=110), SD (funct3=011), OP-IMM-32 and OP-32.
REQ-017 Latency: an accepted instruction SHALL appear on the outputs one cycle after acceptance at the earliest; all outputs are registered.
REQ-018 Buffering: a 2-entry in-order FIFO (output register plus skid register) with occupancy states EMPTY, ONE and TWO.
REQ-019 State transitions:
  - EMPTY to ONE on accept;
  - ONE to TWO on accept without pop;
  - ONE to EMPTY on pop without accept;
  - TWO to ONE on pop;
  - accept and pop in the same cycle in ONE stays in ONE.
REQ-020 in_ready SHALL equal (state != TWO) and be driven from a register; it does not depend combinationally on out_ready.
REQ-021 out_valid SHALL equal (state != EMPTY); out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 flush=1 SHALL force EMPTY at the next edge, drop any same-cycle input, and take priority over accept and pop.

Reset
REQ-023 While rst_n=0, the block SHALL hold state EMPTY, out_valid=0, in_ready=1, every out_* data output at 0, and both counters at 0.
REQ-024 Assertion of rst_n mid-operation SHALL discard all held entries immediately, without waiting for a clock edge.
REQ-025 The first accept SHALL occur no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-026 With DECODE_PERF_CNT_EN defined:
  - perf_decoded SHALL increment on every pop (out_valid and out_ready);
  - perf_illegal SHALL increment on every pop with out_illegal=1;
  - both counters saturate at 0xFFFFFFFF;
  - flush does not clear either counter.
REQ-027 Without DECODE_PERF_CNT_EN, perf_decoded and perf_illegal SHALL be constant 0 and no counter flops exist.

Verification
REQ-028 ADDI: XLEN=64, in_instr 0xFFF00093 -> opcode 0x13, rd 1, rs1 0, fmt 1, imm 0xFFFFFFFFFFFFFFFF, illegal 0, one cycle after accept.
REQ-029 BEQ: in_instr 0xFE000EE3 -> fmt 3, imm -4 (all ones except bits [1:0]=00), illegal 0.
REQ-030 Backpressure: hold out_ready=0 and offer A, B, C back-to-back -> A and B accepted, in_ready=0, C held upstream; then raise out_ready -> A, B, C emitted in order with no loss or duplication.
REQ-031 Width legality: XLEN=32 with in_instr 0x0000B083 (LD) -> illegal 1, fmt 0, imm 0; XLEN=64 with the same instruction -> illegal 0.
REQ-032 Flush and reset:
  - state TWO plus flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, input dropped;
  - rst_n pulsed low mid-stream -> outputs cleared asynchronously.
REQ-033 Counters (macro defined): 5 legal and 2 illegal instructions popped -> perf_decoded=7, perf_illegal=2; counter preset near 0xFFFFFFFF holds at 0xFFFFFFFF after further pops.

Source files
------------

// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//   RV32I/RV64I instruction decode stage with a 2-entry in-order output
//   buffer. The output register holds the head entry; the skid register
//   catches one more instruction so in_ready can be registered.
//
//   Parameters : XLEN (32 or 64), datapath width
//   Macro      : DECODE_PERF_CNT_EN enables the saturating pop/illegal
//                counters; without it perf_* are tied to 0
//   Ports      : clk, rst_n (async, active low), flush
//                in_valid/in_ready/in_instr/in_pc         upstream handshake
//                out_valid/out_ready + decoded out_* fields downstream
//                perf_decoded/perf_illegal                 event counters
module instr_decode_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [31:0]     perf_decoded,
  output logic [31:0]     perf_illegal
);

  localparam logic [6:0] OPC_LUI     = 7'h37;
  localparam logic [6:0] OPC_AUIPC   = 7'h17;
  localparam logic [6:0] OPC_JAL     = 7'h6F;
  localparam logic [6:0] OPC_JALR    = 7'h67;
  localparam logic [6:0] OPC_BRANCH  = 7'h63;
  localparam logic [6:0] OPC_LOAD    = 7'h03;
  localparam logic [6:0] OPC_STORE   = 7'h23;
  localparam logic [6:0] OPC_OPIMM   = 7'h13;
  localparam logic [6:0] OPC_OP      = 7'h33;
  localparam logic [6:0] OPC_MISCMEM = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM  = 7'h73;
  localparam logic [6:0] OPC_OPIMM32 = 7'h1B;
  localparam logic [6:0] OPC_OP32    = 7'h3B;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam bit IS_RV32 = (XLEN == 32);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  // ---------------------------------------------------------------- decode
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [63:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [63:0] w_imm;
  logic [2:0]  w_fmt;
  logic        w_ill;
  dec_t        w_dec;

  assign w_f3 = in_instr[14:12];
  assign w_f7 = in_instr[31:25];

  // Immediates built at 64 bits and truncated, so RV32 needs no special case.
  assign w_imm_i = {{52{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{51{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
  assign w_imm_j = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

  // Every legal major opcode ends in 2'b11, so a compressed/non-32-bit
  // encoding always lands in the default arm.
  always_comb begin
    w_fmt = FMT_R;
    w_ill = 1'b0;
    case (in_instr[6:0])
      OPC_LUI, OPC_AUIPC: w_fmt = FMT_U;
      OPC_JAL:            w_fmt = FMT_J;
      OPC_JALR: begin
        w_fmt = FMT_I;
        w_ill = (w_f3 != 3'b000);
      end
      OPC_BRANCH: begin
        w_fmt = FMT_B;
        w_ill = (w_f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        w_fmt = FMT_I;
        w_ill = (w_f3 == 3'b111) ||
                (IS_RV32 && (w_f3 == 3'b011 || w_f3 == 3'b110));
      end
      OPC_STORE: begin
        w_fmt = FMT_S;
        w_ill = w_f3[2] || (IS_RV32 && w_f3 == 3'b011);
      end
      OPC_OPIMM, OPC_MISCMEM, OPC_SYSTEM: w_fmt = FMT_I;
      OPC_OP: begin
        w_fmt = FMT_R;
        w_ill = !(w_f7 == 7'h00 || w_f7 == 7'h20);
      end
      OPC_OPIMM32: begin
        w_fmt = FMT_I;
        w_ill = IS_RV32;
      end
      OPC_OP32: begin
        w_fmt = FMT_R;
        w_ill = IS_RV32;
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) w_fmt = FMT_R;
  end

  always_comb begin
    w_imm = '0;
    case (w_fmt)
      FMT_I:   w_imm = w_imm_i;
      FMT_S:   w_imm = w_imm_s;
      FMT_B:   w_imm = w_imm_b;
      FMT_U:   w_imm = w_imm_u;
      FMT_J:   w_imm = w_imm_j;
      default: w_imm = '0;
    endcase
  end

  always_comb begin
    w_dec         = '0;
    w_dec.pc      = in_pc;
    w_dec.opcode  = in_instr[6:0];
    w_dec.rd      = in_instr[11:7];
    w_dec.funct3  = w_f3;
    w_dec.rs1     = in_instr[19:15];
    w_dec.rs2     = in_instr[24:20];
    w_dec.funct7  = w_f7;
    w_dec.imm     = w_imm[XLEN-1:0];
    w_dec.fmt     = w_fmt;
    w_dec.illegal = w_ill;
  end

  // ---------------------------------------------------------------- buffer
  state_t r_state;
  logic   r_in_ready, r_out_valid;
  dec_t   r_out, r_skid;
  logic   w_acc, w_pop;

  assign w_acc = in_valid & r_in_ready;
  assign w_pop = r_out_valid & out_ready;

  // in_ready/out_valid are kept as registered copies of the occupancy so
  // neither depends combinationally on the downstream handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_skid      <= '0;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: if (w_acc) begin
          r_out       <= w_dec;
          r_state     <= S_ONE;
          r_out_valid <= 1'b1;
        end
        S_ONE: begin
          if (w_acc && !w_pop) begin
            r_skid     <= w_dec;
            r_state    <= S_TWO;
            r_in_ready <= 1'b0;
          end else if (w_acc) begin
            r_out <= w_dec;
          end else if (w_pop) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        S_TWO: if (w_pop) begin
          r_out      <= r_skid;
          r_state    <= S_ONE;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_pc      = r_out.pc;
  assign out_opcode  = r_out.opcode;
  assign out_rd      = r_out.rd;
  assign out_rs1     = r_out.rs1;
  assign out_rs2     = r_out.rs2;
  assign out_funct3  = r_out.funct3;
  assign out_funct7  = r_out.funct7;
  assign out_imm     = r_out.imm;
  assign out_fmt     = r_out.fmt;
  assign out_illegal = r_out.illegal;

  // -------------------------------------------------------------- counters
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] r_perf_decoded, r_perf_illegal;

  // Counts every downstream handshake, including one coinciding with flush;
  // flush itself never clears the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_decoded <= '0;
      r_perf_illegal <= '0;
    end else if (w_pop) begin
      if (r_perf_decoded != 32'hFFFF_FFFF) r_perf_decoded <= r_perf_decoded + 32'd1;
      if (r_out.illegal && r_perf_illegal != 32'hFFFF_FFFF)
        r_perf_illegal <= r_perf_illegal + 32'd1;
    end
  end

  assign perf_decoded = r_perf_decoded;
  assign perf_illegal = r_perf_illegal;
`else
  assign perf_decoded = '0;
  assign perf_illegal = '0;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [63:0] a_pc, a_imm;
  logic [6:0]  a_opc, a_f7;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_f3, a_fmt;
  logic [31:0] a_pd, a_pi;

  logic        b_in_ready, b_out_valid, b_ill;
  logic [31:0] b_pc, b_imm;
  logic [6:0]  b_opc, b_f7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_f3, b_fmt;
  logic [31:0] b_pd, b_pi;

  instr_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_opcode(a_opc), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm), .out_fmt(a_fmt),
    .out_illegal(a_ill), .perf_decoded(a_pd), .perf_illegal(a_pi));

  instr_decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_opcode(b_opc), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_imm), .out_fmt(b_fmt),
    .out_illegal(b_ill), .perf_decoded(b_pd), .perf_illegal(b_pi));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------------------------------------------------- reference model
  logic [31:0] q_ins[$];
  logic [63:0] q_pc[$];
  logic [31:0] m_dec64 = 0, m_ill64 = 0, m_dec32 = 0, m_ill32 = 0;

  function automatic bit ref_illegal(input logic [31:0] ins, input int xlen);
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    if (ins[1:0] != 2'b11) return 1'b1;
    case (ins[6:0])
      7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73, 7'h13: return 1'b0;
      7'h67: return f3 != 0;
      7'h63: return (f3 == 2) || (f3 == 3);
      7'h03: return (f3 == 7) || (xlen == 32 && (f3 == 3 || f3 == 6));
      7'h23: return (f3 > 3) || (xlen == 32 && f3 == 3);
      7'h33: return !(f7 == 7'h00 || f7 == 7'h20);
      7'h1B, 7'h3B: return xlen == 32;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] ref_fmt(input logic [31:0] ins, input int xlen);
    if (ref_illegal(ins, xlen)) return 3'd0;
    case (ins[6:0])
      7'h23: return 3'd2;
      7'h63: return 3'd3;
      7'h37, 7'h17: return 3'd4;
      7'h6F: return 3'd5;
      7'h33, 7'h3B: return 3'd0;
      default: return 3'd1;
    endcase
  endfunction

  // Immediate value as a signed integer, bit weights summed arithmetically.
  function automatic longint ref_imm(input logic [31:0] ins, input int xlen);
    longint v = 0;
    case (ref_fmt(ins, xlen))
      3'd1: v = longint'(ins[30:20]) - (ins[31] ? 2048 : 0);
      3'd2: v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 2048 : 0);
      3'd3: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 +
                longint'(ins[11:8]) * 2 - (ins[31] ? 4096 : 0);
      3'd4: v = longint'(ins[30:12]) * 4096 - (ins[31] ? (longint'(1) << 31) : 0);
      3'd5: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 +
                longint'(ins[30:21]) * 2 - (ins[31] ? (longint'(1) << 20) : 0);
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 1;
  endfunction

  function automatic logic [31:0] exp_cnt(input logic [31:0] x);
`ifdef DECODE_PERF_CNT_EN
    return x;
`else
    return 32'd0 & x;
`endif
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_edge();
    bit pop = (q_ins.size() != 0) && out_ready;
    bit acc = in_valid && (q_ins.size() < 2);
    if (pop) begin
      m_dec64 = sat_inc(m_dec64);
      m_dec32 = sat_inc(m_dec32);
      if (ref_illegal(q_ins[0], 64)) m_ill64 = sat_inc(m_ill64);
      if (ref_illegal(q_ins[0], 32)) m_ill32 = sat_inc(m_ill32);
    end
    if (flush) begin
      q_ins.delete();
      q_pc.delete();
    end else begin
      if (pop) begin
        void'(q_ins.pop_front());
        void'(q_pc.pop_front());
      end
      if (acc) begin
        q_ins.push_back(in_instr);
        q_pc.push_back(in_pc);
      end
    end
  endfunction

  function automatic void model_reset();
    q_ins.delete();
    q_pc.delete();
    m_dec64 = 0; m_ill64 = 0; m_dec32 = 0; m_ill32 = 0;
  endfunction

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins = $urandom;
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 15))
      0: ins[6:0] = 7'h37;  1: ins[6:0] = 7'h17;  2: ins[6:0] = 7'h6F;
      3: ins[6:0] = 7'h67;  4: ins[6:0] = 7'h63;  5: ins[6:0] = 7'h03;
      6: ins[6:0] = 7'h23;  7: ins[6:0] = 7'h13;  8: ins[6:0] = 7'h33;
      9: ins[6:0] = 7'h0F; 10: ins[6:0] = 7'h73; 11: ins[6:0] = 7'h1B;
      12: ins[6:0] = 7'h3B; 13: ins[6:0] = 7'h12;
      default: ins[6:0] = r[6:0];
    endcase
    if ($urandom_range(0, 2) == 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 3) == 0) ins[14:12] = 3'd0;
    return ins;
  endfunction

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_pc = 64'h1234;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_in_ready !== 1'b1 || b_in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_hs: v64=%b v32=%b r64=%b r32=%b exp v=0 r=1",
                               a_out_valid, b_out_valid, a_in_ready, b_in_ready); end
    checks++;
    if ({a_pc, a_imm, a_opc, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_fmt, a_ill} !== '0)
      begin errors++; $display("FAIL reset_data64: pc=%h imm=%h opc=%h exp all 0", a_pc, a_imm, a_opc); end
    checks++;
    if ({b_pc, b_imm, b_opc, b_rd, b_rs1, b_rs2, b_f3, b_f7, b_fmt, b_ill} !== '0)
      begin errors++; $display("FAIL reset_data32: pc=%h imm=%h opc=%h exp all 0", b_pc, b_imm, b_opc); end
    checks++;
    if ({a_pd, a_pi, b_pd, b_pi} !== '0)
      begin errors++; $display("FAIL reset_cnt: %h %h %h %h exp 0", a_pd, a_pi, b_pd, b_pi); end
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    model_reset();
    cycle();
    checks++;
    if (a_out_valid !== 1'b0)
      begin errors++; $display("FAIL reset_release_idle: out_valid=%b exp 0", a_out_valid); end
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_pc = 64'h8000_0000_0000_0010; out_ready = 1'b0;
    model_edge();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_opc !== 7'h13 || a_rd !== 5'd1 || a_rs1 !== 5'd0 ||
        a_fmt !== 3'd1 || a_imm !== 64'hFFFF_FFFF_FFFF_FFFF || a_ill !== 1'b0 ||
        a_pc !== 64'h8000_0000_0000_0010)
      begin errors++; $display("FAIL addi64: v=%b opc=%h rd=%0d rs1=%0d fmt=%0d imm=%h ill=%b pc=%h",
                               a_out_valid, a_opc, a_rd, a_rs1, a_fmt, a_imm, a_ill, a_pc); end
    checks++;
    if (b_imm !== 32'hFFFF_FFFF || b_fmt !== 3'd1 || b_ill !== 1'b0 || b_pc !== 32'h10)
      begin errors++; $display("FAIL addi32: imm=%h fmt=%0d ill=%b pc=%h", b_imm, b_fmt, b_ill, b_pc); end
    @(negedge clk);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
  endtask

  task automatic test_beq();
    in_valid = 1'b1; in_instr = 32'hFE00_0EE3; in_pc = 64'h40; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (a_fmt !== 3'd3 || a_imm !== 64'hFFFF_FFFF_FFFF_FFFC || a_ill !== 1'b0)
      begin errors++; $display("FAIL beq64: fmt=%0d imm=%h ill=%b exp 3 fffffffffffffffc 0",
                               a_fmt, a_imm, a_ill); end
    checks++;
    if (b_fmt !== 3'd3 || b_imm !== 32'hFFFF_FFFC || b_ill !== 1'b0)
      begin errors++; $display("FAIL beq32: fmt=%0d imm=%h ill=%b exp 3 fffffffc 0", b_fmt, b_imm, b_ill); end
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
  endtask

  task automatic test_width();
    in_valid = 1'b1; in_instr = 32'h0000_B083; in_pc = 64'h80; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (b_ill !== 1'b1 || b_fmt !== 3'd0 || b_imm !== 32'd0)
      begin errors++; $display("FAIL ld_rv32: ill=%b fmt=%0d imm=%h exp 1 0 0", b_ill, b_fmt, b_imm); end
    checks++;
    if (a_ill !== 1'b0 || a_fmt !== 3'd1)
      begin errors++; $display("FAIL ld_rv64: ill=%b fmt=%0d exp 0 1", a_ill, a_fmt); end
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ia = 32'h0000_0093, ib = 32'h0000_0113, ic = 32'h0000_0193;
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = ia; cycle();
    in_instr = ib; cycle();
    checks++;
    if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0 || a_rd !== 5'd1)
      begin errors++; $display("FAIL bp_full: in_ready=%b/%b rd=%0d exp 0/0 1", a_in_ready, b_in_ready, a_rd); end
    in_instr = ic; cycle();
    checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_rd !== 5'd1)
      begin errors++; $display("FAIL bp_hold: in_ready=%b v=%b rd=%0d exp 0 1 1", a_in_ready, a_out_valid, a_rd); end
    out_ready = 1'b1; cycle();
    checks++;
    if (a_rd !== 5'd2 || a_in_ready !== 1'b1 || a_out_valid !== 1'b1)
      begin errors++; $display("FAIL bp_second: rd=%0d in_ready=%b v=%b exp 2 1 1", a_rd, a_in_ready, a_out_valid); end
    cycle();
    checks++;
    if (a_rd !== 5'd3 || a_out_valid !== 1'b1)
      begin errors++; $display("FAIL bp_third: rd=%0d v=%b exp 3 1", a_rd, a_out_valid); end
    in_valid = 1'b0; cycle();
    checks++;
    if (a_out_valid !== 1'b0 || q_ins.size() != 0)
      begin errors++; $display("FAIL bp_drain: v=%b exp 0 (no duplicate)", a_out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h0000_0093; cycle();
    in_instr = 32'h0000_0113; cycle();
    in_instr = 32'h0000_0193; flush = 1'b1; cycle();
    flush = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_empty: v=%b/%b r=%b/%b exp 0 1", a_out_valid, b_out_valid,
                               a_in_ready, b_in_ready); end
    in_valid = 1'b0; cycle();
    checks++;
    if (a_out_valid !== 1'b0)
      begin errors++; $display("FAIL flush_drop: out_valid=%b exp 0", a_out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h1234_5037; in_pc = 64'hABCD;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1)
      begin errors++; $display("FAIL arst_pre: out_valid=%b exp 1", a_out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_pc !== 64'd0 || a_imm !== 64'd0 ||
        a_rd !== 5'd0 || b_out_valid !== 1'b0 || b_pc !== 32'd0)
      begin errors++; $display("FAIL arst_clear: v=%b r=%b pc=%h imm=%h rd=%0d v32=%b exp 0 1 0 0 0 0",
                               a_out_valid, a_in_ready, a_pc, a_imm, a_rd, b_out_valid); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      bit has = q_ins.size() != 0;
      checks++;
      if (a_out_valid !== has || b_out_valid !== has || a_in_ready !== (q_ins.size() < 2) ||
          b_in_ready !== (q_ins.size() < 2))
        begin errors++; $display("FAIL rnd_hs c%0d: v=%b/%b r=%b/%b occ=%0d", c, a_out_valid,
                                 b_out_valid, a_in_ready, b_in_ready, q_ins.size()); end
      if (has) begin
        logic [31:0] ins = q_ins[0];
        logic [63:0] pc = q_pc[0];
        longint i64 = ref_imm(ins, 64);
        longint i32 = ref_imm(ins, 32);
        checks++;
        if (a_pc !== pc || a_opc !== ins[6:0] || a_rd !== ins[11:7] || a_f3 !== ins[14:12] ||
            a_rs1 !== ins[19:15] || a_rs2 !== ins[24:20] || a_f7 !== ins[31:25] ||
            a_imm !== 64'(i64) || a_fmt !== ref_fmt(ins, 64) || a_ill !== ref_illegal(ins, 64))
          begin errors++; $display("FAIL rnd_dec64 c%0d ins=%h: pc=%h imm=%h fmt=%0d ill=%b exp pc=%h imm=%h fmt=%0d ill=%b",
                                   c, ins, a_pc, a_imm, a_fmt, a_ill, pc, 64'(i64), ref_fmt(ins, 64), ref_illegal(ins, 64)); end
        checks++;
        if (b_pc !== pc[31:0] || b_opc !== ins[6:0] || b_rd !== ins[11:7] || b_f3 !== ins[14:12] ||
            b_rs1 !== ins[19:15] || b_rs2 !== ins[24:20] || b_f7 !== ins[31:25] ||
            b_imm !== i32[31:0] || b_fmt !== ref_fmt(ins, 32) || b_ill !== ref_illegal(ins, 32))
          begin errors++; $display("FAIL rnd_dec32 c%0d ins=%h: pc=%h imm=%h fmt=%0d ill=%b exp pc=%h imm=%h fmt=%0d ill=%b",
                                   c, ins, b_pc, b_imm, b_fmt, b_ill, pc[31:0], i32[31:0], ref_fmt(ins, 32), ref_illegal(ins, 32)); end
      end
      checks++;
      if (a_pd !== exp_cnt(m_dec64) || a_pi !== exp_cnt(m_ill64) ||
          b_pd !== exp_cnt(m_dec32) || b_pi !== exp_cnt(m_ill32))
        begin errors++; $display("FAIL rnd_cnt c%0d: %0d %0d %0d %0d exp %0d %0d %0d %0d", c, a_pd, a_pi, b_pd, b_pi,
                                 exp_cnt(m_dec64), exp_cnt(m_ill64), exp_cnt(m_dec32), exp_cnt(m_ill32)); end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = gen_instr();
      in_pc     = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    cycle(); cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_counters();
    logic [31:0] seq [7] = '{32'h0000_0093, 32'h0000_0000, 32'h0010_0113, 32'h0000_0037,
                             32'hFFFF_FFFF, 32'h0000_006F, 32'h0000_0013};
    logic [31:0] d0 = m_dec64, i0 = m_ill64;
    out_ready = 1'b1; in_valid = 1'b1;
    foreach (seq[k]) begin in_instr = seq[k]; cycle(); end
    in_valid = 1'b0; cycle();
    checks++;
    if (a_pd !== exp_cnt(d0 + 7) || a_pi !== exp_cnt(i0 + 2))
      begin errors++; $display("FAIL cnt_7_2: dec=%0d ill=%0d exp %0d %0d", a_pd, a_pi, exp_cnt(d0 + 7), exp_cnt(i0 + 2)); end
    checks++;
    if (b_pd !== exp_cnt(m_dec32) || b_pi !== exp_cnt(m_ill32))
      begin errors++; $display("FAIL cnt32: dec=%0d ill=%0d exp %0d %0d", b_pd, b_pi, exp_cnt(m_dec32), exp_cnt(m_ill32)); end
`ifdef DECODE_PERF_CNT_EN
    force dut64.r_perf_decoded = 32'hFFFF_FFFE;
    force dut64.r_perf_illegal = 32'hFFFF_FFFE;
    #1;
    release dut64.r_perf_decoded;
    release dut64.r_perf_illegal;
    m_dec64 = 32'hFFFF_FFFE; m_ill64 = 32'hFFFF_FFFE;
    in_valid = 1'b1; in_instr = 32'h0000_0000;
    repeat (3) cycle();
    in_valid = 1'b0; cycle();
    checks++;
    if (a_pd !== 32'hFFFF_FFFF || a_pi !== 32'hFFFF_FFFF)
      begin errors++; $display("FAIL cnt_sat: dec=%h ill=%h exp ffffffff ffffffff", a_pd, a_pi); end
`endif
    out_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_addi();
    test_beq();
    test_width();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random(3000);
    test_counters();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
